mem_scheduler: RTL and testbench
================================

# mem_scheduler

Sequencer and arbiter that shares the accelerator's single-port 16-bit feature/weight RAM between several requesters, such as the weight loader, feature-map writer and PE-array fetch. It accepts one request at a time and, for reads, turns it into a burst of consecutive word reads up to one 5x5 output block. For writes, it performs a single-word store. Read data returns on a shared response bus tagged with the requester id. It sits between the CNN control units and the DMA/RAM storage.

## Interface
- `N_REQ`, default 4: number of requesters.
- `ADDR_WIDTH`, default 16: RAM word address width.
- `DATA_WIDTH`, default 16: signed fixed-point word width.
- `LEN_WIDTH`, default 5: burst-length field width.
- `BURST_MAX`, default 25: maximum read burst length, equal to the block size.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: per-requester request.
- `req_rw`  in  N_REQ: 1 = read burst, 0 = single write.
- `req_addr`  in  N_REQ*ADDR_WIDTH: packed base addresses. Requester i occupies slice i.
- `req_len`  in  N_REQ*LEN_WIDTH: packed read lengths. Ignored for writes.
- `req_wdata`  in  N_REQ*DATA_WIDTH: packed write data.
- `req_ready`  out  N_REQ: one-hot, single-cycle accept pulse.
- `mem_en`  out  1: RAM access enable.
- `mem_rw`  out  1: 1 = read, 0 = write.
- `mem_addr`  out  ADDR_WIDTH: RAM address.
- `mem_wdata`  out  DATA_WIDTH: RAM write data.
- `mem_rdata`  in  DATA_WIDTH: RAM read data. Valid one cycle after the read is issued.
- `rsp_valid`  out  1: read data valid.
- `rsp_id`  out  $clog2(N_REQ): id of the requester that owns `rsp_data`.
- `rsp_data`  out  DATA_WIDTH: read word.
- `rsp_last`  out  1: marks the final word of a burst.
- `busy`  out  1: high from accept through burst drain or write completion.

## Operation
- **FSM states:** IDLE, WRITE, READ, DRAIN.
- **IDLE:**
  - If any `req_valid` is high, select a winner and pulse `req_ready[winner]`.
  - Register the winner's rw, addr, len, wdata and id in that cycle.
  - Go to WRITE if rw = 0, otherwise READ.
- **Request holding:** A requester holds `req_valid` and its fields stable until its `req_ready` pulse. If it drops `req_valid` before being granted, the request is withdrawn with no side effects.
- **WRITE:** one cycle with `mem_en`=1, `mem_rw`=0, registered addr and wdata. Then go to IDLE.
- **READ:**
  - Issue L consecutive reads at base+k for k = 0..L-1.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - After the last issue, go to DRAIN.
- **DRAIN:** emit the final response, then go to IDLE.
- **Effective length L:**
  - `req_len` = 0 is treated as 1.
  - `req_len` > BURST_MAX is clamped to BURST_MAX.
- **Responses:**
  - `rsp_data` equals `mem_rdata`, passed through combinationally in the capture cycle.
  - `rsp_valid` is registered and follows each read by one cycle.
  - `rsp_last` coincides with the L-th response.
- **Idle memory outputs:** `mem_en`=0 in IDLE and DRAIN. `mem_addr` and `mem_wdata` hold their last values.
- **Reset:**
  - Every output goes to 0 and the FSM goes to IDLE.
  - An in-flight burst is aborted with no `rsp_last`.
  - The arbitration pointer is reset.

## Timing
- **Accept:** in cycle T.
- **Write:** RAM access at T+1. `busy` is high T..T+1. The next accept is possible at T+2.
- **Read of length L:**
  - Reads are issued at T+1..T+L.
  - `rsp_valid` is high T+2..T+L+1.
  - `rsp_last` is at T+L+1, in DRAIN.
  - The next accept is possible at T+L+2.
- **Bus occupancy:** at most one accept in flight. No pipelining across requests.
- **Arbitration:** combinational over `req_valid` in IDLE only. Requests arriving during a transfer wait.

## Configuration
- **`MEM_SCHED_RR_EN` defined:** round-robin arbitration.
  - Search starts at last winner + 1, modulo N_REQ.
  - After reset, "last winner" is N_REQ-1, so requester 0 has priority first.
- **`MEM_SCHED_RR_EN` undefined:** fixed priority. The lowest index wins. No pointer register.

## Structure
- **Package `mem_sched_pkg`:**
  - state enum `sched_state_t` (IDLE, WRITE, READ, DRAIN);
  - default width constants;
  - `BURST_MAX`;
  - `RW_READ`=1 and `RW_WRITE`=0.
- **Sub-module `rr_arbiter`:**
  - parameter N_REQ;
  - inputs: request vector, advance strobe;
  - outputs: one-hot grant, encoded index;
  - holds the round-robin/fixed-priority `ifdef` internally.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs. All outputs must be 0 and `busy`=0.
- **Write:** requester 1 writes addr 0x0010, data 0x0400.
  - `req_ready`=4'b0010 at T.
  - At T+1: `mem_en`=1, `mem_rw`=0, `mem_addr`=0x0010, `mem_wdata`=0x0400.
  - `busy`=0 at T+2.
- **Read burst:** RAM[0..3] = 5, 3, 8, 8. Requester 0 reads addr 0, len 4.
  - `rsp_data` = 5, 3, 8, 8 at T+2..T+5.
  - `rsp_id`=0.
  - `rsp_last` only at T+5.
  - Len 0 yields exactly one response. Len 31 yields 25 responses.
- **Address wrap:** read at addr 0xFFFE, len 4. `mem_addr` must be 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Arbitration:** all four requesters hold writes valid continuously.
  - With `MEM_SCHED_RR_EN`, grant order is 0, 1, 2, 3, 0.
  - Without it, requester 0 is granted every accept.
- **Reset mid-burst:** assert `rst_n` after 2 of 25 responses.
  - Outputs go to 0 immediately, with no `rsp_last`.
  - After release, pending requests are re-arbitrated starting from requester 0.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared types and default widths for the RAM sequencer/arbiter.
package mem_sched_pkg;

    localparam int unsigned N_REQ_DEF      = 4;
    localparam int unsigned ADDR_WIDTH_DEF = 16;
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned LEN_WIDTH_DEF  = 5;
    localparam int unsigned BURST_MAX      = 25;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

endpackage

// File: rtl/mem_sched_if.sv
// Request, RAM and response bus of mem_scheduler; slave is the scheduler side.
interface mem_sched_if
    import mem_sched_pkg::*;
#(
    parameter int unsigned N_REQ      = N_REQ_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
);
    localparam int unsigned ID_WIDTH = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_rw;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*LEN_WIDTH-1:0]  req_len;
    logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            req_ready;

    logic                        mem_en;
    logic                        mem_rw;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic [DATA_WIDTH-1:0]       mem_rdata;

    logic                        rsp_valid;
    logic [ID_WIDTH-1:0]         rsp_id;
    logic [DATA_WIDTH-1:0]       rsp_data;
    logic                        rsp_last;
    logic                        busy;

    modport master (
        output req_valid, req_rw, req_addr, req_len, req_wdata, mem_rdata,
        input  req_ready, mem_en, mem_rw, mem_addr, mem_wdata,
        input  rsp_valid, rsp_id, rsp_data, rsp_last, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_len, req_wdata, mem_rdata,
        output req_ready, mem_en, mem_rw, mem_addr, mem_wdata,
        output rsp_valid, rsp_id, rsp_data, rsp_last, busy
    );

endinterface

// File: rtl/mem_scheduler_rr_arbiter.sv
// Request arbiter: round-robin when MEM_SCHED_RR_EN is defined, else fixed lowest-index priority.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
`ifdef MEM_SCHED_RR_EN
    input  logic                     clk,
    input  logic                     rst_n,
`endif
    input  logic [N_REQ-1:0]         req,
    input  logic                     advance,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] index
);
    localparam int unsigned IW = $clog2(N_REQ);

    logic found;

`ifdef MEM_SCHED_RR_EN
    logic [IW-1:0] last_q;
    logic [IW-1:0] cand;

    // Search from last winner + 1, wrapping modulo N_REQ.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IW'((32'(last_q) + i) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N_REQ - 1);
        end else if (advance && found) begin
            last_q <= index;
        end
    end
`else
    logic unused_advance;
    assign unused_advance = advance;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!found && req[IW'(i)]) begin
                found          = 1'b1;
                grant[IW'(i)]  = 1'b1;
                index          = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_scheduler.sv
// Shares a single-port RAM between requesters: single-word writes, clamped read bursts.
// Arbitration policy selected by MEM_SCHED_RR_EN (defined: round-robin, else fixed priority).
module mem_scheduler #(
    parameter int unsigned N_REQ      = mem_sched_pkg::N_REQ_DEF,
    parameter int unsigned ADDR_WIDTH = mem_sched_pkg::ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = mem_sched_pkg::DATA_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH  = mem_sched_pkg::LEN_WIDTH_DEF,
    parameter int unsigned BURST_MAX  = mem_sched_pkg::BURST_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_sched_if.slave bus
);
    import mem_sched_pkg::*;

    localparam int unsigned ID_WIDTH = $clog2(N_REQ);

    sched_state_t          state_q, state_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_last_q, rsp_last_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    logic [N_REQ-1:0]      grant;
    logic [ID_WIDTH-1:0]   win_idx;
    logic                  accept;
    logic                  sel_rw;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [LEN_WIDTH-1:0]  eff_len;

    assign accept = (state_q == IDLE) && (|bus.req_valid);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
`ifdef MEM_SCHED_RR_EN
        .clk     (clk),
        .rst_n   (rst_n),
`endif
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant),
        .index   (win_idx)
    );

    // Winner's request fields.
    always_comb begin
        sel_rw    = RW_WRITE;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_len   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_idx == ID_WIDTH'(i)) begin
                sel_rw    = bus.req_rw[i];
                sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_len   = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // Length 0 means one word; anything above a block is clamped to a block.
    always_comb begin
        if (sel_len == '0) begin
            eff_len = LEN_WIDTH'(1);
        end else if (sel_len > LEN_WIDTH'(BURST_MAX)) begin
            eff_len = LEN_WIDTH'(BURST_MAX);
        end else begin
            eff_len = sel_len;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        id_d        = id_q;
        rem_d       = rem_q;
        rsp_valid_d = mem_en_q && (mem_rw_q == RW_READ);
        rsp_last_d  = rsp_valid_d && (rem_q == '0);
        rsp_id_d    = rsp_valid_d ? id_q : rsp_id_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_en_d   = 1'b1;
                    mem_rw_d   = sel_rw;
                    mem_addr_d = sel_addr;
                    id_d       = win_idx;
                    rem_d      = eff_len - LEN_WIDTH'(1);
                    if (sel_rw == RW_WRITE) begin
                        mem_wdata_d = sel_wdata;
                        state_d     = WRITE;
                    end else begin
                        state_d     = READ;
                    end
                end
            end
            WRITE: begin
                mem_en_d = 1'b0;
                state_d  = IDLE;
            end
            READ: begin
                if (rem_q == '0) begin
                    mem_en_d = 1'b0;
                    state_d  = DRAIN;
                end else begin
                    rem_d      = rem_q - LEN_WIDTH'(1);
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_id_q    <= '0;
            id_q        <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_id_q    <= rsp_id_d;
            id_q        <= id_d;
            rem_q       <= rem_d;
        end
    end

    // Accept pulse and busy are combinational so they land in the accept cycle.
    assign bus.req_ready = (rst_n && state_q == IDLE) ? grant : '0;
    assign bus.busy      = (state_q != IDLE) || (|bus.req_ready);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_valid_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed self-checking bench for mem_scheduler with a behavioural single-port RAM.
module tb_mem_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_sched_if bus ();

    mem_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:65535];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_rw) bus.mem_rdata <= ram[bus.mem_addr];
            else            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_word(input logic [15:0] a);
        logic [15:0] tbl [0:3];
        tbl[0] = 16'd5; tbl[1] = 16'd3; tbl[2] = 16'd8; tbl[3] = 16'd8;
        if (a < 16'd4) return tbl[a[1:0]];
        return 16'(32'(a) * 3 + 7);
    endfunction

    task automatic set_req(input int id, input logic rw, input logic [15:0] addr,
                           input logic [4:0] len, input logic [15:0] wd);
        bus.req_valid[id]          = 1'b1;
        bus.req_rw[id]             = rw;
        bus.req_addr[id*16 +: 16]  = addr;
        bus.req_len[id*5 +: 5]     = len;
        bus.req_wdata[id*16 +: 16] = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  32'(bus.req_ready), 0);
        check({tag, "_en"},     32'(bus.mem_en), 0);
        check({tag, "_rw"},     32'(bus.mem_rw), 0);
        check({tag, "_addr"},   32'(bus.mem_addr), 0);
        check({tag, "_wdata"},  32'(bus.mem_wdata), 0);
        check({tag, "_rvalid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rid"},    32'(bus.rsp_id), 0);
        check({tag, "_rdata"},  32'(bus.rsp_data), 0);
        check({tag, "_rlast"},  32'(bus.rsp_last), 0);
        check({tag, "_busy"},   32'(bus.busy), 0);
    endtask

    task automatic run_read(input int id, input logic [15:0] base, input logic [4:0] len, input int n);
        logic [3:0] exp_ready;
        exp_ready = 4'b0001 << id;
        set_req(id, 1'b1, base, len, 16'h0);
        #1;
        check("rd_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("rd_busy_t", 32'(bus.busy), 1);
        for (int c = 1; c <= n + 2; c++) begin
            tick();
            if (c == 1) bus.req_valid[id] = 1'b0;
            check("rd_en", 32'(bus.mem_en), 32'(c <= n));
            if (c <= n) begin
                check("rd_addr", 32'(bus.mem_addr), 32'(16'(base + 16'(c - 1))));
                check("rd_rw", 32'(bus.mem_rw), 1);
            end
            check("rd_rvalid", 32'(bus.rsp_valid), 32'(c >= 2 && c <= n + 1));
            if (c >= 2 && c <= n + 1) begin
                check("rd_data", 32'(bus.rsp_data), 32'(exp_word(16'(base + 16'(c - 2)))));
                check("rd_id", 32'(bus.rsp_id), 32'(id));
                check("rd_last", 32'(bus.rsp_last), 32'(c == n + 1));
            end else begin
                check("rd_last_idle", 32'(bus.rsp_last), 0);
            end
            check("rd_busy", 32'(bus.busy), 32'(c <= n + 1));
        end
    endtask

    initial begin
        int exp_order [0:4];
        logic [3:0] oh;

        for (int i = 0; i < 65536; i++) ram[i] = 16'(i * 3 + 7);
        ram[0] = 16'd5; ram[1] = 16'd3; ram[2] = 16'd8; ram[3] = 16'd8;
        bus.mem_rdata = 16'h0;

        // Reset with random inputs
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 4'($urandom);
            bus.req_rw    = 4'($urandom);
            bus.req_addr  = 64'({$urandom, $urandom});
            bus.req_len   = 20'($urandom);
            bus.req_wdata = 64'({$urandom, $urandom});
            #1;
            check_all_zero("rst");
            tick();
        end
        bus.req_valid = '0;
        rst_n = 1'b1;
        tick();

        // Single write from requester 1
        set_req(1, 1'b0, 16'h0010, 5'd0, 16'h0400);
        #1;
        check("wr_ready", 32'(bus.req_ready), 32'(4'b0010));
        check("wr_busy_t", 32'(bus.busy), 1);
        tick();
        bus.req_valid = '0;
        check("wr_en", 32'(bus.mem_en), 1);
        check("wr_rw", 32'(bus.mem_rw), 0);
        check("wr_addr", 32'(bus.mem_addr), 32'h0010);
        check("wr_wdata", 32'(bus.mem_wdata), 32'h0400);
        check("wr_busy_t1", 32'(bus.busy), 1);
        tick();
        check("wr_busy_t2", 32'(bus.busy), 0);
        check("wr_en_t2", 32'(bus.mem_en), 0);
        check("wr_addr_hold", 32'(bus.mem_addr), 32'h0010);
        check("wr_ram", 32'(ram[16'h0010]), 32'h0400);

        // Read bursts: basic, len 0, clamped len 31, address wrap
        run_read(0, 16'h0000, 5'd4, 4);
        run_read(2, 16'h0100, 5'd0, 1);
        run_read(3, 16'h0200, 5'd31, 25);
        run_read(1, 16'hFFFE, 5'd4, 4);

        // Arbitration with all four writes held valid, from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'(16'h0020 + i), 5'd0, 16'(16'h1000 + i));
`ifdef MEM_SCHED_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int k = 0; k < 5; k++) begin
            #1;
            oh = 4'b0001 << exp_order[k];
            check("arb_ready", 32'(bus.req_ready), 32'(oh));
            tick();
            check("arb_addr", 32'(bus.mem_addr), 32'(16'h0020 + exp_order[k]));
            check("arb_wdata", 32'(bus.mem_wdata), 32'(16'h1000 + exp_order[k]));
            tick();
        end
        bus.req_valid = '0;
        tick();

        // Reset during a 25-word burst after two responses
        set_req(2, 1'b1, 16'h0200, 5'd25, 16'h0);
        #1;
        check("mb_ready", 32'(bus.req_ready), 32'(4'b0100));
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        check("mb_rvalid_pre", 32'(bus.rsp_valid), 1);
        check("mb_data_pre", 32'(bus.rsp_data), 32'(exp_word(16'h0201)));
        rst_n = 1'b0;
        #1;
        check_all_zero("mb_rst");
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'(16'h0030 + i), 5'd0, 16'(16'h2000 + i));
        tick();
        check("mb_rlast_rst", 32'(bus.rsp_last), 0);
        check("mb_ready_rst", 32'(bus.req_ready), 0);
        rst_n = 1'b1;
        #1;
        check("mb_rearb0", 32'(bus.req_ready), 32'(4'b0001));
        tick();
        check("mb_rearb0_addr", 32'(bus.mem_addr), 32'h0030);
        check("mb_rlast_post", 32'(bus.rsp_last), 0);
        tick();
`ifdef MEM_SCHED_RR_EN
        check("mb_rearb1", 32'(bus.req_ready), 32'(4'b0010));
`else
        check("mb_rearb1", 32'(bus.req_ready), 32'(4'b0001));
`endif
        bus.req_valid = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
